// File: rtl/opb_register_bank.sv
// OPB slave register bank: C_NUM_REGS user registers plus COMMIT and STATUS words,
// with optional shadow-and-commit update and a fixed IDLE->ACK->GAP handshake.
module opb_register_bank #(
  parameter logic [31:0] C_BASEADDR  = 32'h01000500,
  parameter logic [31:0] C_HIGHADDR  = 32'h010005FF,
  parameter int          C_NUM_REGS  = 4,
  parameter logic [31:0] C_RESET_VAL = 32'h00000000,
  parameter int          C_SHADOW    = 0
) (
  input  logic                     OPB_Clk,
  input  logic                     OPB_Rst,
  input  logic [0:31]              OPB_ABus,
  input  logic [0:3]               OPB_BE,
  input  logic [0:31]              OPB_DBus,
  input  logic                     OPB_RNW,
  input  logic                     OPB_select,
  input  logic                     OPB_seqAddr,
  output logic [0:31]              Sl_DBus,
  output logic                     Sl_xferAck,
  output logic                     Sl_errAck,
  output logic                     Sl_retry,
  output logic                     Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0] user_data_out,
  output logic [C_NUM_REGS-1:0]    user_wr_stb,
  input  logic [31:0]              user_status_in
);

  typedef enum logic [1:0] {IDLE, ACK, GAP} state_t;

  localparam bit          SHADOW_EN  = (C_SHADOW != 0);
  localparam logic [29:0] COMMIT_IDX = 30'(C_NUM_REGS);
  localparam logic [29:0] STATUS_IDX = 30'(C_NUM_REGS + 1);

  state_t state_q, state_d;

  logic [31:0] outReg_q [C_NUM_REGS];
  logic [31:0] outReg_d [C_NUM_REGS];
  logic [31:0] shadow_q [C_NUM_REGS];
  logic [31:0] shadow_d [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] wrStb_q, wrStb_d;

  logic        rnw_q;
  logic [0:3]  be_q;
  logic [31:0] wrData_q;
  logic        isReg_q, isCommit_q, isStatus_q;
  logic [3:0]  regIdx_q;

  logic [29:0] addrWord;
  logic [29:0] wordIdx;
  logic        hit;
  logic        isReg, isCommit, isStatus;
  logic        mapped;
  logic        inAck;
  logic        doWrite;
  logic        unusedInputs;

  // Bus bit k is user bit 31-k, so numeric copies between [0:31] and [31:0] need no swizzle.
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [0:3]  byteEn);
    logic [31:0] res;
    res = oldVal;
    for (int b = 0; b < 4; b++) begin
      if (byteEn[b]) res[31-8*b -: 8] = newVal[31-8*b -: 8];
    end
    return res;
  endfunction

  assign unusedInputs = &{1'b0, OPB_seqAddr, OPB_ABus[30:31]};

  assign addrWord = OPB_ABus[0:29];
  assign wordIdx  = addrWord - C_BASEADDR[31:2];
  assign hit      = OPB_select && (addrWord >= C_BASEADDR[31:2]) && (addrWord <= C_HIGHADDR[31:2]);
  assign isReg    = (wordIdx < COMMIT_IDX);
  assign isCommit = (wordIdx == COMMIT_IDX);
  assign isStatus = (wordIdx == STATUS_IDX);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hit) state_d = ACK;
      ACK:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Acks are gated by reset so a transfer aborted in ACK is never acknowledged.
  assign mapped     = isReg_q || isStatus_q || (isCommit_q && SHADOW_EN);
  assign inAck      = (state_q == ACK) && !OPB_Rst;
  assign Sl_xferAck = inAck && mapped;
  assign Sl_errAck  = inAck && !mapped;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign doWrite    = (state_q == ACK) && !rnw_q;

  always_comb begin
    Sl_DBus = '0;
    if (inAck && rnw_q) begin
      if (isStatus_q) begin
        Sl_DBus = user_status_in;
      end else if (isReg_q) begin
        for (int i = 0; i < C_NUM_REGS; i++) begin
          if (regIdx_q == 4'(i)) Sl_DBus = SHADOW_EN ? shadow_q[i] : outReg_q[i];
        end
      end
    end
  end

  always_comb begin
    outReg_d = outReg_q;
    shadow_d = shadow_q;
    wrStb_d  = '0;
    if (doWrite) begin
      if (isReg_q) begin
        for (int i = 0; i < C_NUM_REGS; i++) begin
          if (regIdx_q == 4'(i)) begin
            if (SHADOW_EN) begin
              shadow_d[i] = mergeBytes(shadow_q[i], wrData_q, be_q);
            end else begin
              outReg_d[i] = mergeBytes(outReg_q[i], wrData_q, be_q);
              wrStb_d[i]  = |be_q;
            end
          end
        end
      end
      if (isCommit_q && SHADOW_EN && wrData_q[0] && be_q[3]) begin
        outReg_d = shadow_q;
        wrStb_d  = '1;
      end
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q <= IDLE;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        outReg_q[i] <= C_RESET_VAL;
        shadow_q[i] <= C_RESET_VAL;
      end
      wrStb_q    <= '0;
      rnw_q      <= 1'b1;
      be_q       <= '0;
      wrData_q   <= '0;
      isReg_q    <= 1'b0;
      isCommit_q <= 1'b0;
      isStatus_q <= 1'b0;
      regIdx_q   <= '0;
    end else begin
      state_q  <= state_d;
      outReg_q <= outReg_d;
      shadow_q <= shadow_d;
      wrStb_q  <= wrStb_d;
      // The request is captured on the hit so the ACK cycle acts on a stable copy.
      if (state_q == IDLE && hit) begin
        rnw_q      <= OPB_RNW;
        be_q       <= OPB_BE;
        wrData_q   <= OPB_DBus;
        isReg_q    <= isReg;
        isCommit_q <= isCommit;
        isStatus_q <= isStatus;
        regIdx_q   <= wordIdx[3:0];
      end
    end
  end

  always_comb begin
    user_data_out = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      user_data_out[32*i +: 32] = outReg_q[i];
    end
  end

  assign user_wr_stb = wrStb_q;

endmodule
